prbs_gen_chk: RTL and testbench

- Parametrised next-generation PRBS source and checker for DCFEB link tests; single clock domain.
- Generator produces WIDTH bits per clock from a selectable polynomial, with single-bit error injection.
- Self-synchronising checker runs on received words, with a lock state machine and a saturating errored-word counter.
- Sits between the link serialiser interface and slow-control status registers.

---
 rtl/prbs_gen_chk_pkg.sv | 66 ++++++
 rtl/prbs_gen_chk_if.sv | 37 +++
 rtl/prbs_gen_chk_chk_core.sv | 151 +++++++++++++++
 rtl/prbs_gen_chk.sv | 93 +++++++++
 tb/tb_prbs_gen_chk.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_gen_chk_pkg.sv
// prbs_gen_chk_pkg
//   Shared types, polynomial tables and the parallel LFSR step used by the
//   PRBS generator and checker.
//   Contents:
//     prbs_mode_t   polynomial select (PRBS7/15/23/31)
//     chk_state_t   checker lock state (FILL/SEARCH/LOCKED)
//     PRBS_LEN/TAP  register length L and inner tap T for each polynomial
//     prbs_step()   advance an LFSR by nbits serial steps in one call
package prbs_gen_chk_pkg;

   localparam int MAX_LEN   = 31;
   localparam int MAX_WIDTH = 64;

   typedef enum logic [1:0] {
      PRBS7  = 2'd0,
      PRBS15 = 2'd1,
      PRBS23 = 2'd2,
      PRBS31 = 2'd3
   } prbs_mode_t;

   typedef enum logic [1:0] {
      CHK_FILL   = 2'd0,
      CHK_SEARCH = 2'd1,
      CHK_LOCKED = 2'd2
   } chk_state_t;

   // x^L + x^T + 1
   localparam logic [4:0] PRBS_LEN [4] = '{5'd7, 5'd15, 5'd23, 5'd31};
   localparam logic [4:0] PRBS_TAP [4] = '{5'd6, 5'd14, 5'd18, 5'd28};

   typedef struct packed {
      logic [MAX_LEN-1:0]   state;
      logic [MAX_WIDTH-1:0] data;
   } prbs_step_t;

   // Each serial step computes b = s[L-1] ^ s[T-1] and shifts b in at the
   // bottom. The first bit produced ends up in data[nbits-1], so the low
   // nbits of .data are already in transmit order (MSB first in time).
   function automatic prbs_step_t prbs_step(input logic [MAX_LEN-1:0] state,
                                            input prbs_mode_t         mode,
                                            input int                 nbits);
      prbs_step_t         r;
      logic [4:0]         len_m1;
      logic [4:0]         tap_m1;
      logic [4:0]         len;
      logic               b;
      logic [MAX_LEN-1:0] mask;
      len    = PRBS_LEN[mode];
      len_m1 = len - 5'd1;
      tap_m1 = PRBS_TAP[mode] - 5'd1;
      mask   = {MAX_LEN{1'b1}} >> (5'd31 - len);
      r.state = state;
      r.data  = '0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         if (i < nbits) begin
            b       = r.state[len_m1] ^ r.state[tap_m1];
            r.state = {r.state[MAX_LEN-2:0], b};
            r.data  = {r.data[MAX_WIDTH-2:0], b};
         end
      end
      // Bits above L-1 are never read; keep them zero so the state is tidy.
      r.state = r.state & mask;
      return r;
   endfunction

endpackage

// File: rtl/prbs_gen_chk_if.sv
// prbs_gen_chk_if
//   Bundles the generator controls, TX/RX data paths and checker status of
//   prbs_gen_chk.
//   slave  : the PRBS block (drives tx_*, locked, word_err, err_cnt, chk_state)
//   master : the link/slow-control side (drives en, mode, inj_err, rx_*, clr_cnt)
//   Handshake: tx_valid qualifies tx_data and rx_valid qualifies rx_data in
//   the same cycle; there is no backpressure, a word is taken whenever its
//   valid is high and is ignored entirely when valid is low.
interface prbs_gen_chk_if
   import prbs_gen_chk_pkg::*;
#(
   parameter int WIDTH     = 48,
   parameter int ERR_CNT_W = 16
);
   logic                 en;
   logic [1:0]           mode;
   logic                 inj_err;
   logic [WIDTH-1:0]     tx_data;
   logic                 tx_valid;
   logic [WIDTH-1:0]     rx_data;
   logic                 rx_valid;
   logic                 clr_cnt;
   logic                 locked;
   logic                 word_err;
   logic [ERR_CNT_W-1:0] err_cnt;
   chk_state_t           chk_state;

   modport slave (
      input  en, mode, inj_err, rx_data, rx_valid, clr_cnt,
      output tx_data, tx_valid, locked, word_err, err_cnt, chk_state
   );

   modport master (
      output en, mode, inj_err, rx_data, rx_valid, clr_cnt,
      input  tx_data, tx_valid, locked, word_err, err_cnt, chk_state
   );
endinterface

// File: rtl/prbs_gen_chk_chk_core.sv
// prbs_chk_core
//   Self-synchronising PRBS checker: keeps the last L received bits, forms
//   the per-bit error vector e[m] = r[m]^r[m-L]^r[m-T] and runs the
//   FILL/SEARCH/LOCKED lock machine with a saturating errored-word counter.
//   Ports:
//     i_clk, i_rst_n  clock, asynchronous active-low reset
//     i_mode          polynomial in use
//     i_restart       polynomial changed: back to FILL, history cleared
//     i_rx_data/valid received word, bit WIDTH-1 first in time
//     i_clr_cnt       synchronous clear of the error counter
//     o_locked        checker in LOCKED
//     o_word_err      one-cycle pulse per errored word while LOCKED
//     o_err_cnt       errored words seen while LOCKED, saturating
//     o_state         current lock state
module prbs_chk_core
   import prbs_gen_chk_pkg::*;
#(
   parameter int WIDTH       = 48,
   parameter int ERR_CNT_W   = 16,
   parameter int LOCK_CNT    = 32,
   parameter int UNLOCK_ERRS = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  prbs_mode_t           i_mode,
   input  logic                 i_restart,
   input  logic [WIDTH-1:0]     i_rx_data,
   input  logic                 i_rx_valid,
   input  logic                 i_clr_cnt,
   output logic                 o_locked,
   output logic                 o_word_err,
   output logic [ERR_CNT_W-1:0] o_err_cnt,
   output chk_state_t           o_state
);

   localparam int LC_W = $clog2(LOCK_CNT + 1);
   localparam int UE_W = $clog2(UNLOCK_ERRS + 1);

   chk_state_t           r_state;
   chk_state_t           w_state_nxt;
   logic [MAX_LEN-1:0]   r_hist;         // bit 0 = most recent received bit
   logic [2:0]           r_fill_cnt;
   logic [LC_W-1:0]      r_clean_cnt;
   logic [UE_W-1:0]      r_err_run;
   logic [ERR_CNT_W-1:0] r_err_cnt;
   logic                 r_word_err;

   logic [MAX_LEN-1:0]   w_hist_nxt;
   logic [WIDTH-1:0]     w_err_vec;
   logic                 w_word_err;
   logic [4:0]           w_len_m1;
   logic [4:0]           w_tap_m1;
   int                   w_fill_words;
   logic                 w_fill_done;
   logic                 w_lock_hit;
   logic                 w_unlock_hit;
   logic                 w_cnt_inc;

   assign w_len_m1     = PRBS_LEN[i_mode] - 5'd1;
   assign w_tap_m1     = PRBS_TAP[i_mode] - 5'd1;
   assign w_fill_words = (int'(PRBS_LEN[i_mode]) + WIDTH - 1) / WIDTH;

   // Walk the word in time order, checking each bit against the history
   // (which already includes the earlier bits of this same word).
   always_comb begin
      logic v_bit;
      v_bit      = 1'b0;
      w_hist_nxt = r_hist;
      w_err_vec  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         v_bit                = i_rx_data[WIDTH-1-i];
         w_err_vec[WIDTH-1-i] = v_bit ^ w_hist_nxt[w_len_m1] ^ w_hist_nxt[w_tap_m1];
         w_hist_nxt           = {w_hist_nxt[MAX_LEN-2:0], v_bit};
      end
   end

   assign w_word_err   = |w_err_vec;
   assign w_fill_done  = (int'(r_fill_cnt) + 1) >= w_fill_words;
   assign w_lock_hit   = !w_word_err && (r_clean_cnt == LC_W'(LOCK_CNT - 1));
   assign w_unlock_hit = w_word_err && (r_err_run == UE_W'(UNLOCK_ERRS - 1));
   assign w_cnt_inc    = !i_restart && i_rx_valid && (r_state == CHK_LOCKED) && w_word_err;

   // ---- FSM: state register ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= CHK_FILL;
      else          r_state <= w_state_nxt;
   end

   // ---- FSM: next state ----
   always_comb begin
      w_state_nxt = r_state;
      if (i_restart) begin
         w_state_nxt = CHK_FILL;
      end else if (i_rx_valid) begin
         case (r_state)
            CHK_FILL:   if (w_fill_done)  w_state_nxt = CHK_SEARCH;
            CHK_SEARCH: if (w_lock_hit)   w_state_nxt = CHK_LOCKED;
            CHK_LOCKED: if (w_unlock_hit) w_state_nxt = CHK_SEARCH;
            default:                      w_state_nxt = CHK_FILL;
         endcase
      end
   end

   // ---- FSM: outputs ----
   always_comb begin
      o_locked   = (r_state == CHK_LOCKED);
      o_state    = r_state;
      o_word_err = r_word_err;
      o_err_cnt  = r_err_cnt;
   end

   // History and run-length counters
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hist      <= '0;
         r_fill_cnt  <= '0;
         r_clean_cnt <= '0;
         r_err_run   <= '0;
      end else if (i_restart) begin
         r_hist      <= '0;
         r_fill_cnt  <= '0;
         r_clean_cnt <= '0;
         r_err_run   <= '0;
      end else if (i_rx_valid) begin
         r_hist <= w_hist_nxt;
         if (r_state == CHK_FILL) r_fill_cnt <= w_fill_done ? 3'd0 : r_fill_cnt + 3'd1;
         else                     r_fill_cnt <= '0;
         if (r_state == CHK_SEARCH && !w_word_err && !w_lock_hit)
            r_clean_cnt <= r_clean_cnt + LC_W'(1);
         else
            r_clean_cnt <= '0;
         if (r_state == CHK_LOCKED && w_word_err && !w_unlock_hit)
            r_err_run <= r_err_run + UE_W'(1);
         else
            r_err_run <= '0;
      end
   end

   // Errored-word counter; a clear in the same cycle as an increment wins.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err_cnt  <= '0;
         r_word_err <= 1'b0;
      end else begin
         r_word_err <= w_cnt_inc;
         if (i_clr_cnt)                   r_err_cnt <= '0;
         else if (w_cnt_inc && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

endmodule

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk
//   PRBS source and self-synchronising checker for link tests.
//   The generator emits WIDTH bits per clock from the selected polynomial
//   with optional single-bit error injection; the checker (prbs_chk_core)
//   locks onto received words and counts errored words.
//   Ports:
//     i_clk    clock, rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      prbs_gen_chk_if.slave: en, mode, inj_err, tx_data, tx_valid,
//              rx_data, rx_valid, clr_cnt, locked, word_err, err_cnt,
//              chk_state
module prbs_gen_chk
   import prbs_gen_chk_pkg::*;
#(
   parameter int WIDTH       = 48,
   parameter int ERR_CNT_W   = 16,
   parameter int LOCK_CNT    = 32,
   parameter int UNLOCK_ERRS = 4
) (
   input logic            i_clk,
   input logic            i_rst_n,
   prbs_gen_chk_if.slave  bus
);

   prbs_mode_t         r_mode;
   logic [MAX_LEN-1:0] r_lfsr;
   logic [WIDTH-1:0]   r_tx_data;
   logic               r_tx_valid;
   logic               r_inj_pend;

   prbs_mode_t         w_mode_in;
   logic               w_mode_chg;
   logic               w_inj;
   prbs_step_t         w_step;
   logic [WIDTH-1:0]   w_tx_word;
   logic               w_unused_step;

   assign w_mode_in     = prbs_mode_t'(bus.mode);
   assign w_mode_chg    = (w_mode_in != r_mode);
   // A pulse arriving in the same cycle as a valid word applies at once.
   assign w_inj         = r_inj_pend | bus.inj_err;
   assign w_step        = prbs_step(r_lfsr, r_mode, WIDTH);
   // Injection flips the first bit in time only; the LFSR is untouched.
   assign w_tx_word     = w_step.data[WIDTH-1:0] ^ {w_inj, {(WIDTH-1){1'b0}}};
   assign w_unused_step = ^w_step.data;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mode     <= PRBS7;
         r_lfsr     <= '1;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_inj_pend <= 1'b0;
      end else if (w_mode_chg) begin
         // Reseed; this cycle's word is dropped, giving a one-cycle gap.
         r_mode     <= w_mode_in;
         r_lfsr     <= '1;
         r_tx_valid <= 1'b0;
         r_inj_pend <= w_inj;
      end else if (bus.en) begin
         r_lfsr     <= w_step.state;
         r_tx_data  <= w_tx_word;
         r_tx_valid <= 1'b1;
         r_inj_pend <= 1'b0;
      end else begin
         r_tx_valid <= 1'b0;
         r_inj_pend <= w_inj;
      end
   end

   assign bus.tx_data  = r_tx_data;
   assign bus.tx_valid = r_tx_valid;

   prbs_chk_core #(
      .WIDTH       (WIDTH),
      .ERR_CNT_W   (ERR_CNT_W),
      .LOCK_CNT    (LOCK_CNT),
      .UNLOCK_ERRS (UNLOCK_ERRS)
   ) u_chk (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_mode     (r_mode),
      .i_restart  (w_mode_chg),
      .i_rx_data  (bus.rx_data),
      .i_rx_valid (bus.rx_valid),
      .i_clr_cnt  (bus.clr_cnt),
      .o_locked   (bus.locked),
      .o_word_err (bus.word_err),
      .o_err_cnt  (bus.err_cnt),
      .o_state    (bus.chk_state)
   );

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk
//   Drives prbs_gen_chk (WIDTH=8, ERR_CNT_W=4) with loopback, forced and
//   randomly corrupted RX traffic, and compares every cycle's outputs with a
//   reference model built on the bit recurrence b[n] = b[n-L] ^ b[n-T].
module tb_prbs_gen_chk;

   localparam int WIDTH       = 8;
   localparam int ERR_CNT_W   = 4;
   localparam int LOCK_CNT    = 32;
   localparam int UNLOCK_ERRS = 4;
   localparam int EXP_W       = 1 + WIDTH + 1 + 1 + ERR_CNT_W;
   localparam int CNT_MAX     = (1 << ERR_CNT_W) - 1;

   localparam int SRC_IDLE = 0;
   localparam int SRC_LOOP = 1;
   localparam int SRC_FF   = 2;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   prbs_gen_chk_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) bus ();

   prbs_gen_chk #(
      .WIDTH       (WIDTH),
      .ERR_CNT_W   (ERR_CNT_W),
      .LOCK_CNT    (LOCK_CNT),
      .UNLOCK_ERRS (UNLOCK_ERRS)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // ---------------- reference model ----------------
   bit               gen_hist[$];   // generated bits, newest at the back
   bit               rx_hist[$];    // received bits, newest at the back
   int               cur_mode;
   bit               inj_pend;
   logic             m_tx_valid;
   logic [WIDTH-1:0] m_tx_data;
   bit               m_locked;
   bit               m_word_err;
   int               m_err_cnt;
   int               fill_left;
   int               clean_run;
   int               err_run;

   function automatic int poly_len(input int mode);
      case (mode)
         0: return 7;
         1: return 15;
         2: return 23;
         default: return 31;
      endcase
   endfunction

   function automatic int poly_tap(input int mode);
      case (mode)
         0: return 6;
         1: return 14;
         2: return 18;
         default: return 28;
      endcase
   endfunction

   function automatic void seed_gen();
      gen_hist.delete();
      for (int i = 0; i < poly_len(cur_mode); i++) gen_hist.push_back(1'b1);
   endfunction

   function automatic void restart_chk();
      rx_hist.delete();
      fill_left  = (poly_len(cur_mode) + WIDTH - 1) / WIDTH;
      m_locked   = 1'b0;
      clean_run  = 0;
      err_run    = 0;
      m_word_err = 1'b0;
   endfunction

   function automatic void model_reset();
      cur_mode   = 0;
      seed_gen();
      inj_pend   = 1'b0;
      m_tx_valid = 1'b0;
      m_tx_data  = '0;
      m_err_cnt  = 0;
      restart_chk();
   endfunction

   // One rising edge, using the inputs currently on the bus.
   function automatic void model_edge();
      int               len;
      int               tap;
      int               n;
      bit               b;
      bit               r;
      bit               err;
      logic [WIDTH-1:0] word;
      if (int'(bus.mode) != cur_mode) begin
         cur_mode   = int'(bus.mode);
         seed_gen();
         m_tx_valid = 1'b0;
         inj_pend   = inj_pend | bus.inj_err;
         restart_chk();
         if (bus.clr_cnt) m_err_cnt = 0;
         return;
      end
      len = poly_len(cur_mode);
      tap = poly_tap(cur_mode);
      // generator
      if (bus.en) begin
         word = '0;
         for (int i = 0; i < WIDTH; i++) begin
            n = gen_hist.size();
            b = gen_hist[n-len] ^ gen_hist[n-tap];
            gen_hist.push_back(b);
            word = {word[WIDTH-2:0], b};
         end
         while (gen_hist.size() > 64) void'(gen_hist.pop_front());
         if (inj_pend || bus.inj_err) word[WIDTH-1] = ~word[WIDTH-1];
         inj_pend   = 1'b0;
         m_tx_data  = word;
         m_tx_valid = 1'b1;
      end else begin
         m_tx_valid = 1'b0;
         inj_pend   = inj_pend | bus.inj_err;
      end
      // checker
      m_word_err = 1'b0;
      if (bus.rx_valid) begin
         err = 1'b0;
         for (int i = WIDTH - 1; i >= 0; i--) begin
            r = bus.rx_data[i];
            n = rx_hist.size();
            if (fill_left == 0) err = err | (r ^ rx_hist[n-len] ^ rx_hist[n-tap]);
            rx_hist.push_back(r);
         end
         while (rx_hist.size() > 64) void'(rx_hist.pop_front());
         if (fill_left > 0) begin
            fill_left--;
         end else if (!m_locked) begin
            if (err) clean_run = 0;
            else     clean_run++;
            if (clean_run == LOCK_CNT) begin
               m_locked  = 1'b1;
               clean_run = 0;
               err_run   = 0;
            end
         end else if (err) begin
            m_word_err = 1'b1;
            if (m_err_cnt < CNT_MAX) m_err_cnt++;
            err_run++;
            if (err_run == UNLOCK_ERRS) begin
               m_locked  = 1'b0;
               err_run   = 0;
               clean_run = 0;
            end
         end else begin
            err_run = 0;
         end
      end
      if (bus.clr_cnt) m_err_cnt = 0;
   endfunction

   function automatic logic [EXP_W-1:0] exp_vec();
      return {m_tx_valid, m_tx_data, m_locked, m_word_err, ERR_CNT_W'(m_err_cnt)};
   endfunction

   // ---------------- scoreboard ----------------
   logic [EXP_W-1:0] exp_q[$];
   int               vectors;
   int               miscompares;

   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      logic [EXP_W-1:0] g;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = {bus.tx_valid, bus.tx_data, bus.locked, bus.word_err, bus.err_cnt};
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL out_vec t=%0t st=%0d got tv=%b td=%h lk=%b we=%b ec=%0d, expected tv=%b td=%h lk=%b we=%b ec=%0d",
                     $time, bus.chk_state,
                     g[EXP_W-1], g[EXP_W-2 -: WIDTH], g[ERR_CNT_W+1], g[ERR_CNT_W], g[ERR_CNT_W-1:0],
                     e[EXP_W-1], e[EXP_W-2 -: WIDTH], e[ERR_CNT_W+1], e[ERR_CNT_W], e[ERR_CNT_W-1:0]);
         end
      end
   end

   // ---------------- driver ----------------
   int rx_src;
   int flip_pct;
   int gap_pct;

   task automatic cycle();
      int k;
      if (gap_pct > 0) bus.en = ($urandom_range(0, 99) >= gap_pct);
      case (rx_src)
         SRC_LOOP: begin bus.rx_data = m_tx_data; bus.rx_valid = m_tx_valid; end
         SRC_FF:   begin bus.rx_data = '1;        bus.rx_valid = 1'b1;       end
         default:  begin bus.rx_data = '0;        bus.rx_valid = 1'b0;       end
      endcase
      if (flip_pct > 0 && $urandom_range(0, 99) < flip_pct) begin
         k = $urandom_range(0, WIDTH - 1);
         bus.rx_data[k] = ~bus.rx_data[k];
      end
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge();
      exp_q.push_back(exp_vec());
      #1;
      bus.inj_err = 1'b0;
      bus.clr_cnt = 1'b0;
   endtask

   // Asynchronous reset in the middle of a cycle: outputs must clear before
   // the next sampling point.
   task automatic async_reset();
      rst_n = 1'b0;
      model_reset();
      exp_q[exp_q.size()-1] = exp_vec();
   endtask

   task automatic inject_every_other(input int n);
      repeat (n) begin
         bus.inj_err = 1'b1;
         cycle();
         cycle();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      vectors     = 0;
      miscompares = 0;
      rx_src      = SRC_IDLE;
      flip_pct    = 0;
      gap_pct     = 0;
      rst_n       = 1'b0;
      bus.en      = 1'b0;
      bus.mode    = 2'd0;
      bus.inj_err = 1'b0;
      bus.rx_data = '0;
      bus.rx_valid = 1'b0;
      bus.clr_cnt = 1'b0;
      model_reset();

      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (3) cycle();                 // EN=0: outputs stay 0

      bus.en = 1'b1;                      // first words, then loopback lock
      rx_src = SRC_LOOP;
      repeat (45) cycle();

      gap_pct = 15;                       // random EN gaps while locked
      repeat (30) cycle();
      gap_pct = 0;
      bus.en  = 1'b1;
      repeat (3) cycle();

      bus.inj_err = 1'b1;                 // single injection
      cycle();
      repeat (8) cycle();

      bus.en = 1'b0;                      // pending + merged pulses while EN=0
      bus.inj_err = 1'b1;
      cycle();
      bus.inj_err = 1'b1;
      cycle();
      repeat (2) cycle();
      bus.en = 1'b1;
      repeat (6) cycle();

      bus.clr_cnt = 1'b1;
      cycle();
      rx_src = SRC_FF;                    // 4 forced words: unlock
      repeat (4) cycle();
      rx_src = SRC_LOOP;                  // relock
      repeat (45) cycle();

      inject_every_other(22);             // saturate the 4-bit counter
      bus.inj_err = 1'b1;                 // clear coinciding with increment
      cycle();
      bus.clr_cnt = 1'b1;
      cycle();
      repeat (3) cycle();

      inject_every_other(3);              // non-zero count to carry over
      repeat (2) cycle();
      bus.mode = 2'd3;                    // mode 0 -> 3 mid-stream
      repeat (50) cycle();

      flip_pct = 8;                       // random bit errors on PRBS31
      repeat (80) cycle();
      flip_pct = 0;
      repeat (45) cycle();

      bus.mode = 2'd1;
      repeat (45) cycle();
      bus.mode = 2'd2;
      gap_pct  = 10;
      repeat (60) cycle();
      gap_pct  = 0;
      bus.en   = 1'b1;
      repeat (5) cycle();

      async_reset();                      // reset mid-stream
      repeat (2) cycle();
      rst_n = 1'b1;
      repeat (12) cycle();

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
